// File: rtl/tinychip_pkg.sv
// Shared TinyChip definitions: fetch FSM states and default fetch-stage geometry.
package tinychip_pkg;

  localparam int PC_W_DEF       = 10;
  localparam int INSTR_W_DEF    = 9;
  localparam int START_ADDR_DEF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// TinyChip fetch stage: owns the PC, reads the combinational ROM and offers instructions on valid/ready.
// Optional macro FETCH_BOUNDS_EN traps fetches at or beyond PROG_LEN into a sticky error state.
module instr_fetch
  import tinychip_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int START_ADDR = START_ADDR_DEF,
  parameter int PROG_LEN   = 1024,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   retired_cnt
);

  fetch_state_e r_state, w_state_next;

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_instr_pc;
  logic               r_valid;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;

  logic            w_start;
  logic            w_accept;
  logic            w_bad;
  logic [PC_W-1:0] w_pc_next;

  assign w_start  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept = (r_state == RUN) && r_valid && instr_ready;

  always_comb begin
    w_pc_next = r_instr_pc;
    if (w_start)
      w_pc_next = PC_W'(START_ADDR);
    else if (w_accept)
      w_pc_next = branch_taken ? branch_target : r_instr_pc + 1'b1;
  end

`ifdef FETCH_BOUNDS_EN
  logic r_error;

  // Halt retires the program cleanly, so it masks a bad follow-on address.
  assign w_bad = w_accept && !halt && (32'(w_pc_next) >= 32'(PROG_LEN));
  assign error = r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_error <= 1'b0;
    else if (w_bad)
      r_error <= 1'b1;
  end
`else
  logic w_unused_prog_len;

  assign w_unused_prog_len = (PROG_LEN > 0);
  assign w_bad = 1'b0;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = RUN;
      RUN: begin
        if (w_accept && halt)
          w_state_next = DONE;
        else if (w_bad)
          w_state_next = ERR;
      end
      DONE:    if (w_start) w_state_next = RUN;
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
    end else if (w_start) begin
      // The ROM read of START_ADDR happens on the next edge, giving one cycle of latency.
      r_instr_pc <= PC_W'(START_ADDR);
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == RUN) begin
      if (w_accept && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
      if (w_accept && halt) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end else if (w_bad) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_instr    <= imem_data;
        r_instr_pc <= w_pc_next;
        r_valid    <= 1'b1;
      end
    end
  end

  assign imem_addr   = w_pc_next;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign done        = r_done;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the main handshake flow, plus hand sequences
// for mid-run reset, out-of-range branch (build-dependent) and counter saturation / PC wrap.
module tb_instr_fetch;

  localparam int PC_W     = 10;
  localparam int INSTR_W  = 9;
  localparam int PROG_LEN = 16;
  localparam int CNT_W    = 16;

  logic               clk;
  logic               reset;
  logic               start;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               halt;
  logic               done;
  logic               error;
  logic [CNT_W-1:0]   retired_cnt;

  int n_checks;
  int n_fail;

  instr_fetch #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .START_ADDR(0), .PROG_LEN(PROG_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt), .done(done),
    .error(error), .retired_cnt(retired_cnt)
  );

  function automatic logic [INSTR_W-1:0] rom_f(input logic [PC_W-1:0] a);
    logic [PC_W-1:0] t;
    t = a * 10'd7 + 10'd3;
    return t[INSTR_W-1:0];
  endfunction

  always_comb imem_data = rom_f(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic b, input logic [PC_W-1:0] t,
                       input logic h);
    start = s; instr_ready = r; branch_taken = b; branch_target = t; halt = h;
  endtask

  typedef struct {
    logic            st;
    logic            rdy;
    logic            br;
    logic [PC_W-1:0] tgt;
    logic            hlt;
    logic            e_v;
    logic [PC_W-1:0] e_pc;
    logic            e_done;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //          st    rdy   br    tgt      hlt   e_v   e_pc     done  cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 1'b0, 16'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h002, 1'b0, 16'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 10'h030, 1'b1, 1'b1, 10'h002, 1'b0, 16'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h002, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h002, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h003, 1'b0, 16'd3};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h004, 1'b0, 16'd4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h005, 1'b0, 16'd5};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 10'h00C, 1'b0, 1'b1, 10'h00C, 1'b0, 16'd6};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 10'h006, 1'b0, 1'b1, 10'h006, 1'b0, 16'd7};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h007, 1'b0, 16'd8};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 10'h030, 1'b1, 1'b0, 10'h007, 1'b1, 16'd9};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h007, 1'b1, 16'd9};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 16'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 16'd0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_pc",    32'(instr_pc),    32'd0);
    chk("reset_instr", 32'(instr),       32'd0);
    chk("reset_done",  32'(done),        32'd0);
    chk("reset_error", 32'(error),       32'd0);
    chk("reset_cnt",   32'(retired_cnt), 32'd0);

    // Main flow: sequential fetch, stall, ignored start/branch/halt, redirects, halt, restart.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].rdy, vecs[i].br, vecs[i].tgt, vecs[i].hlt);
      step();
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_pc", i),    32'(instr_pc),    32'(vecs[i].e_pc));
      chk($sformatf("v%0d_done", i),  32'(done),        32'(vecs[i].e_done));
      chk($sformatf("v%0d_cnt", i),   32'(retired_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].e_v)
        chk($sformatf("v%0d_instr", i), 32'(instr), 32'(rom_f(vecs[i].e_pc)));
    end

    // Reset asserted between edges mid-run.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step();
    step();
    chk("pre_reset_pc", 32'(instr_pc), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_valid", 32'(instr_valid), 32'd0);
    chk("mid_reset_pc",    32'(instr_pc),    32'd0);
    chk("mid_reset_instr", 32'(instr),       32'd0);
    chk("mid_reset_cnt",   32'(retired_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    chk("post_reset_idle_valid", 32'(instr_valid), 32'd0);
    chk("post_reset_idle_cnt",   32'(retired_cnt), 32'd0);
    chk("post_reset_idle_done",  32'(done),        32'd0);

    // Branch to 0x10: trapped with bounds checking, fetched without it.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step();
    chk("b6_first_valid", 32'(instr_valid), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 10'h010, 1'b0);
    step();
`ifdef FETCH_BOUNDS_EN
    chk("b6_error", 32'(error),       32'd1);
    chk("b6_done",  32'(done),        32'd1);
    chk("b6_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step();
    step();
    chk("b6_error_sticky", 32'(error),       32'd1);
    chk("b6_valid_sticky", 32'(instr_valid), 32'd0);
`else
    chk("b6_valid", 32'(instr_valid), 32'd1);
    chk("b6_pc",    32'(instr_pc),    32'h010);
    chk("b6_instr", 32'(instr),       32'(rom_f(10'h010)));
    chk("b6_error", 32'(error),       32'd0);

    // Long sequential run: PC wraps at 1024, counter saturates at 65535.
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step();
    @(negedge clk);
    instr_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      step();
      if (i == 1023) begin
        chk("wrap_pc",  32'(instr_pc),    32'd0);
        chk("wrap_cnt", 32'(retired_cnt), 32'd1024);
      end
    end
    chk("sat_cnt", 32'(retired_cnt), 32'd65535);
    chk("sat_pc",  32'(instr_pc),    32'd4);
    chk("sat_instr", 32'(instr),     32'(rom_f(10'd4)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
